bcd2bin_seq: RTL and testbench
==============================

Name: bcd2bin_seq

Overview:
- Sequential BCD-to-binary converter; the inverse of the team's combinational binary-to-BCD block.
- Uses reverse double-dabble: one right-shift plus per-digit correction per clock.
- Sits between display/keypad-style decimal front ends and binary datapaths.
- Valid/ready handshake on both sides, one conversion in flight at a time.

Parameters:
- D, default 3: number of BCD digits at the input (D >= 1).
- W, default 10: binary output width.
  - Must satisfy 2^W >= 10^D; checked by an elaboration-time assertion.
  - A violation is a fatal elaboration error.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  bcd holds a conversion request.
- in_ready  output  1  block can accept a request.
- bcd  input  4*D  packed digits {..., hundreds, tens, ones}; ones in [3:0].
- out_valid  output  1  bin and err are valid.
- out_ready  input  1  consumer accepts the result.
- bin  output  W  binary result.
- err  output  1  at least one input digit > 9.

Behaviour:
- Reset:
  - One clock; reset is asynchronous and active-low (clk, rst_n).
  - rst_n low immediately forces: state IDLE, in_ready=1, out_valid=0, bin=0, err=0, shift register=0, iteration counter=0.
  - Reset mid-conversion discards the conversion; no output is produced for it.
- States: IDLE, CALC, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid&&in_ready at an edge:
    - load shift register {bcd_reg[4D-1:0], bin_reg[4D-1:0]} = {bcd, 0};
    - err_reg = OR over digits of (digit > 9);
    - counter = 0; go to CALC.
- CALC:
  - in_ready=0.
  - Each edge:
    - shift the whole 8D-bit register right by 1;
    - then, in each 4-bit BCD digit of the shifted value, subtract 3 if the digit >= 8;
    - counter increments.
  - After exactly 4*D CALC edges, go to DONE.
- DONE:
  - out_valid=1.
  - bin = err_reg ? 0 : bin_reg[W-1:0] (upper bits of bin_reg are zero for legal input).
  - err = err_reg.
  - bin and err are stable while out_valid=1 && out_ready=0.
  - On out_valid&&out_ready at an edge: go to IDLE; out_valid drops and in_ready rises in the same cycle.
- Latency:
  - Accept edge = edge 0; out_valid rises after edge 4*D (12 cycles for D=3).
  - Minimum request-to-request spacing is 4*D+2 cycles.
- No overlap: in_valid is ignored outside IDLE, and bcd is sampled only at the accept edge.
- out_ready asserted before out_valid has no effect.
- Invalid digits: the conversion still runs its full 4*D cycles, giving constant latency; the result is forced to 0 with err=1.
- Outputs are registered, with no combinational path from in_valid to out_valid.
- in_ready does not depend combinationally on out_ready.

Decomposition:
- Shared package bcd_pkg contains:
  - typedef enum logic [1:0] {IDLE, CALC, DONE} bcd_state_t;
  - localparam DIGIT_W = 4;
  - function bcd_digit_ok(logic [3:0] d), returning d <= 9.
- The package is reusable by the binary-to-BCD side.
- One natural sub-module: bcd_digit_sub3, a combinational 4-bit stage that outputs d-3 if d >= 8, else d.
  - Instantiated D times via generate.
- Counter width: $clog2(4*D+1).

Test Plan:
- D=3, W=10: bcd=12'h999, in_valid pulse -> after 12 cycles out_valid=1, bin=999 (10'h3E7), err=0.
- bcd=12'h000 -> bin=0, err=0. bcd=12'h255 -> bin=255. bcd=12'h100 -> bin=100. All at fixed 12-cycle latency.
- Backpressure with bcd=12'h409:
  - hold out_ready=0 for 5 cycles after out_valid -> bin=409 stable and in_ready=0 throughout;
  - a new in_valid during that window is ignored;
  - out_ready=1 -> in_ready=1 on the next cycle.
- Invalid input: bcd=12'h1A3 -> after 12 cycles out_valid=1, err=1, bin=0. A following request with bcd=12'h123 -> err=0, bin=123.
- Reset mid-op:
  - accept 12'h777, then deassert rst_n at cycle 5 -> out_valid=0 and in_ready=1 immediately, with no result emitted;
  - after release, 12'h042 -> bin=42.
- Back-to-back with out_ready tied 1: three requests (12'h001, 12'h500, 12'h999) -> results 1, 500, 999 in order, each 14 cycles apart.

Source files
------------

// File: rtl/bcd_pkg.sv
// ---------------------------------------------------------------------------
// bcd_pkg : digit-level types and helpers shared by the BCD<->binary blocks
// Rev 1.0 : initial release
// ---------------------------------------------------------------------------
`default_nettype none

package bcd_pkg;

  typedef enum logic [1:0] {IDLE, CALC, DONE} bcd_state_t;

  localparam int DIGIT_W = 4;

  function automatic logic bcd_digit_ok(input logic [3:0] d);
    return (d <= 4'd9);
  endfunction

endpackage

`default_nettype wire

// File: rtl/bcd_digit_sub3.sv
// ---------------------------------------------------------------------------
// bcd_digit_sub3 : one reverse double-dabble correction stage (d>=8 -> d-3)
// Rev 1.0 : initial release
// ---------------------------------------------------------------------------
`default_nettype none

module bcd_digit_sub3 (
  input  logic [3:0] i_digit,
  output logic [3:0] o_digit
);

  assign o_digit = i_digit[3] ? (i_digit - 4'd3) : i_digit;

endmodule

`default_nettype wire

// File: rtl/bcd2bin_seq.sv
// ---------------------------------------------------------------------------
// bcd2bin_seq : sequential BCD-to-binary converter, one shift per clock
// Rev 1.0 : initial release
// ---------------------------------------------------------------------------
`default_nettype none

module bcd2bin_seq
  import bcd_pkg::*;
#(
  parameter int D = 3,
  parameter int W = 10
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [4*D-1:0]       bcd,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [W-1:0]         bin,
  output logic                 err
);

  localparam int HALF_W = DIGIT_W * D;
  localparam int SR_W   = 2 * HALF_W;
  localparam int CNT_W  = $clog2(4 * D + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(4 * D - 1);

  generate
    if ((2.0 ** W) < (10.0 ** D)) begin : g_width_check
      $fatal(1, "bcd2bin_seq: W too small to hold 10^D - 1");
    end
  endgenerate

  bcd_state_t        state_q, state_d;
  logic [SR_W-1:0]   sr_q, sr_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              err_reg_q, err_reg_d;
  logic [W-1:0]      bin_q, bin_d;
  logic              err_q, err_d;

  logic [SR_W-1:0]   w_shifted;
  logic [HALF_W-1:0] w_corr;
  logic [SR_W-1:0]   w_sr_calc;
  logic              w_bcd_err;

  assign w_shifted = sr_q >> 1;

  // Correction applies only to the BCD half; the binary half just collects bits.
  generate
    for (genvar i = 0; i < D; i++) begin : g_digit
      bcd_digit_sub3 u_sub3 (
        .i_digit (w_shifted[HALF_W + i*DIGIT_W +: DIGIT_W]),
        .o_digit (w_corr[i*DIGIT_W +: DIGIT_W])
      );
    end
  endgenerate

  assign w_sr_calc = {w_corr, w_shifted[HALF_W-1:0]};

  always_comb begin
    w_bcd_err = 1'b0;
    for (int i = 0; i < D; i++) begin
      w_bcd_err = w_bcd_err | ~bcd_digit_ok(bcd[i*DIGIT_W +: DIGIT_W]);
    end
  end

  always_comb begin
    state_d   = state_q;
    sr_d      = sr_q;
    cnt_d     = cnt_q;
    err_reg_d = err_reg_q;
    bin_d     = bin_q;
    err_d     = err_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          sr_d      = {bcd, {HALF_W{1'b0}}};
          err_reg_d = w_bcd_err;
          cnt_d     = '0;
          state_d   = CALC;
        end
      end
      CALC: begin
        sr_d  = w_sr_calc;
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_LAST) begin
          state_d = DONE;
          bin_d   = err_reg_q ? '0 : W'(w_sr_calc[HALF_W-1:0]);
          err_d   = err_reg_q;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      sr_q      <= '0;
      cnt_q     <= '0;
      err_reg_q <= 1'b0;
      bin_q     <= '0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      sr_q      <= sr_d;
      cnt_q     <= cnt_d;
      err_reg_q <= err_reg_d;
      bin_q     <= bin_d;
      err_q     <= err_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign bin       = bin_q;
  assign err       = err_q;

endmodule

`default_nettype wire

// File: tb/tb_bcd2bin_seq.sv
// ---------------------------------------------------------------------------
// tb_bcd2bin_seq : directed self-checking bench for bcd2bin_seq (D=3, W=10)
// Rev 1.0 : initial release
// ---------------------------------------------------------------------------
`default_nettype none

module tb_bcd2bin_seq;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [11:0] bcd;
  logic        out_valid;
  logic        out_ready;
  logic [9:0]  bin;
  logic        err;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  bcd2bin_seq #(.D(3), .W(10)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .bcd       (bcd),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .bin       (bin),
    .err       (err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Drives one request at a negedge and waits (bounded) for the result.
  task automatic convert(input logic [11:0] v, input logic [9:0] eb,
                         input logic ee, input string tag);
    int lat;
    chk({tag, "_in_ready"}, {31'd0, in_ready}, 32'd1);
    in_valid = 1'b1;
    bcd      = v;
    @(negedge clk);
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    chk({tag, "_latency"}, lat, 32'd12);
    chk({tag, "_bin"}, {22'd0, bin}, {22'd0, eb});
    chk({tag, "_err"}, {31'd0, err}, {31'd0, ee});
  endtask

  task automatic expect_idle(input string tag);
    @(negedge clk);
    chk({tag, "_idle_in_ready"}, {31'd0, in_ready}, 32'd1);
    chk({tag, "_idle_out_valid"}, {31'd0, out_valid}, 32'd0);
  endtask

  logic [11:0] b2b_vec [3];
  logic [9:0]  b2b_exp [3];
  int          b2b_time [3];
  int          sent;
  int          got;

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    bcd       = 12'h000;
    out_ready = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_in_ready",  {31'd0, in_ready},  32'd1);
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_bin",       {22'd0, bin},       32'd0);
    chk("rst_err",       {31'd0, err},       32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Basic conversions, out_ready held high before results appear
    convert(12'h999, 10'd999, 1'b0, "c999");
    expect_idle("c999");
    convert(12'h000, 10'd0,   1'b0, "c000");
    expect_idle("c000");
    convert(12'h255, 10'd255, 1'b0, "c255");
    expect_idle("c255");
    convert(12'h100, 10'd100, 1'b0, "c100");
    expect_idle("c100");

    // Backpressure: result must hold, new requests are ignored
    out_ready = 1'b0;
    convert(12'h409, 10'd409, 1'b0, "bp409");
    in_valid = 1'b1;
    bcd      = 12'h888;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("bp_out_valid", {31'd0, out_valid}, 32'd1);
      chk("bp_bin",       {22'd0, bin},       32'd409);
      chk("bp_in_ready",  {31'd0, in_ready},  32'd0);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    expect_idle("bp_release");
    repeat (3) begin
      @(negedge clk);
      chk("bp_no_ghost", {31'd0, out_valid}, 32'd0);
    end

    // Invalid digit forces zero result, followed by a clean request
    convert(12'h1A3, 10'd0,   1'b1, "bad1A3");
    expect_idle("bad1A3");
    convert(12'h123, 10'd123, 1'b0, "c123");
    expect_idle("c123");

    // Asynchronous reset during a conversion
    in_valid = 1'b1;
    bcd      = 12'h777;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (5) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("mid_rst_in_ready",  {31'd0, in_ready},  32'd1);
    chk("mid_rst_bin",       {22'd0, bin},       32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 14; i++) begin
      @(negedge clk);
      chk("mid_rst_no_result", {31'd0, out_valid}, 32'd0);
    end
    convert(12'h042, 10'd42, 1'b0, "c042");
    expect_idle("c042");

    // Back-to-back with out_ready tied high
    b2b_vec[0] = 12'h001; b2b_exp[0] = 10'd1;
    b2b_vec[1] = 12'h500; b2b_exp[1] = 10'd500;
    b2b_vec[2] = 12'h999; b2b_exp[2] = 10'd999;
    sent = 0;
    got  = 0;
    for (int i = 0; i < 80 && got < 3; i++) begin
      @(negedge clk);
      if (out_valid) begin
        chk("b2b_bin", {22'd0, bin}, {22'd0, b2b_exp[got]});
        chk("b2b_err", {31'd0, err}, 32'd0);
        b2b_time[got] = cyc;
        got++;
      end
      if (in_ready && sent < 3) begin
        in_valid = 1'b1;
        bcd      = b2b_vec[sent];
        sent++;
      end else begin
        in_valid = 1'b0;
      end
    end
    in_valid = 1'b0;
    chk("b2b_count", got, 32'd3);
    if (got == 3) begin
      chk("b2b_gap1", b2b_time[1] - b2b_time[0], 32'd14);
      chk("b2b_gap2", b2b_time[2] - b2b_time[1], 32'd14);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
